// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Sequential signed multiply / divide unit for the multicycle MIPS datapath.
// One iteration per clock: radix-2 Booth multiply or restoring divide, then a
// single FIX cycle that applies sign correction and loads HI/LO. A divide by
// zero short-circuits through a one-cycle DZ state and leaves HI/LO untouched.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   start_mult        one-cycle request: signed op_a * op_b
//   start_div         one-cycle request: signed op_a / op_b (mult wins if both)
//   op_a, op_b        operands, sampled only on an accepted start
//   hi_out, lo_out    product[2W-1:W]/product[W-1:0] or remainder/quotient
//   busy              operation in progress (includes the done cycle)
//   done              one-cycle completion pulse
//   division_by_zero  last accepted divide had op_b == 0; sticky until next start
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             division_by_zero
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DZ   = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Booth accumulator high half carries one extra sign bit so that subtracting
  // the most negative multiplicand cannot overflow before the arithmetic shift.
  // During a divide the same registers hold remainder (hi) and quotient (lo).
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             acc_qm1_q, acc_qm1_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             accept_s;
  logic             take_mult_s;
  logic             take_div_s;
  logic             div_zero_s;
  logic             last_iter_s;
  logic [WIDTH:0]   opnd_ext_s;
  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return negate(v);
    end else begin
      return v;
    end
  endfunction

  // busy stays high through the done cycle, so IDLE alone is not enough to accept
  assign accept_s    = (state_q == S_IDLE) && !busy_q;
  assign take_mult_s = accept_s && start_mult;
  assign take_div_s  = accept_s && start_div && !start_mult;
  assign div_zero_s  = (op_b == {WIDTH{1'b0}});
  assign last_iter_s = (cnt_q == LAST_ITER);

  // Booth add/subtract selected by the {q0, q-1} bit pair
  always_comb begin
    opnd_ext_s = {opnd_q[WIDTH-1], opnd_q};
    case ({acc_lo_q[0], acc_qm1_q})
      2'b01:   booth_sum_s = acc_hi_q + opnd_ext_s;
      2'b10:   booth_sum_s = acc_hi_q - opnd_ext_s;
      default: booth_sum_s = acc_hi_q;
    endcase
  end

  // Restoring divide trial subtraction on unsigned magnitudes
  always_comb begin
    div_shift_s = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_mult_s) begin
          state_d = S_MULT;
        end else if (take_div_s) begin
          if (div_zero_s) begin
            state_d = S_DZ;
          end else begin
            state_d = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MULT, S_DIV: begin
        if (last_iter_s) begin
          state_d = S_FIX;
        end else begin
          state_d = state_q;
        end
      end
      S_FIX:   state_d = S_IDLE;
      S_DZ:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-state logic
  always_comb begin
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    acc_qm1_d = acc_qm1_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    op_div_d  = op_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (take_mult_s) begin
          busy_d    = 1'b1;
          dz_d      = 1'b0;
          cnt_d     = CNT_ZERO;
          op_div_d  = 1'b0;
          opnd_d    = op_a;
          acc_hi_d  = {(WIDTH + 1){1'b0}};
          acc_lo_d  = op_b;
          acc_qm1_d = 1'b0;
        end else if (take_div_s) begin
          busy_d    = 1'b1;
          dz_d      = div_zero_s;
          done_d    = div_zero_s;   // DZ completes in the very next cycle
          cnt_d     = CNT_ZERO;
          op_div_d  = 1'b1;
          opnd_d    = magnitude(op_b);
          acc_hi_d  = {(WIDTH + 1){1'b0}};
          acc_lo_d  = magnitude(op_a);
          acc_qm1_d = 1'b0;
          neg_quo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
          neg_rem_d = op_a[WIDTH-1];
        end else begin
          busy_d = 1'b0;
        end
      end
      S_MULT: begin
        // arithmetic right shift of {sum, P_lo, q-1}
        acc_hi_d  = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
        acc_lo_d  = {booth_sum_s[0], acc_lo_q[WIDTH-1:1]};
        acc_qm1_d = acc_lo_q[0];
        cnt_d     = cnt_q + CNT_ONE;
      end
      S_DIV: begin
        if (div_diff_s[WIDTH]) begin
          acc_hi_d = div_shift_s;
        end else begin
          acc_hi_d = div_diff_s;
        end
        acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff_s[WIDTH]};
        cnt_d    = cnt_q + CNT_ONE;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (op_div_q) begin
          hi_d = neg_rem_q ? negate(acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0];
          lo_d = neg_quo_q ? negate(acc_lo_q) : acc_lo_q;
        end else begin
          hi_d = acc_hi_q[WIDTH-1:0];
          lo_d = acc_lo_q;
        end
      end
      S_DZ: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_hi_q  <= {(WIDTH + 1){1'b0}};
      acc_lo_q  <= {WIDTH{1'b0}};
      acc_qm1_q <= 1'b0;
      opnd_q    <= {WIDTH{1'b0}};
      cnt_q     <= CNT_ZERO;
      op_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      acc_qm1_q <= acc_qm1_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      op_div_q  <= op_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi_out           = hi_q;
  assign lo_out           = lo_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign division_by_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. A transaction-level model (busy
// countdown plus plain 64-bit arithmetic) predicts every output each cycle;
// directed cases pin exact literal results and timing; a random phase fires
// starts, busy-time starts and operand changes freely.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        division_by_zero;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_mult       (start_mult),
    .start_div        (start_div),
    .op_a             (op_a),
    .op_b             (op_b),
    .hi_out           (hi_out),
    .lo_out           (lo_out),
    .busy             (busy),
    .done             (done),
    .division_by_zero (division_by_zero)
  );

  always #5 clk = ~clk;

  // Reference arithmetic
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // returns {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a busy countdown; done is its last cycle
  int          m_remain;
  logic        m_dz, m_pend_dz;
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_remain  <= 0;
      m_dz      <= 1'b0;
      m_pend_dz <= 1'b0;
      m_hi      <= 32'd0;
      m_lo      <= 32'd0;
      m_pend_hi <= 32'd0;
      m_pend_lo <= 32'd0;
    end else if (m_remain != 0) begin
      m_remain <= m_remain - 1;
      if (m_remain == 2 && !m_pend_dz) begin
        m_hi <= m_pend_hi;
        m_lo <= m_pend_lo;
      end
    end else if (start_mult || start_div) begin
      m_dz      <= 1'b0;
      m_pend_dz <= 1'b0;
      m_remain  <= 34;
      if (start_mult) begin
        {m_pend_hi, m_pend_lo} <= ref_mul(op_a, op_b);
      end else if (op_b == 32'd0) begin
        m_dz      <= 1'b1;
        m_pend_dz <= 1'b1;
        m_remain  <= 1;
      end else begin
        {m_pend_hi, m_pend_lo} <= ref_div(op_a, op_b);
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("cyc_busy", 64'(busy), 64'(m_remain != 0));
      chk("cyc_done", 64'(done), 64'(m_remain == 1));
      chk("cyc_dz", 64'(division_by_zero), 64'(m_dz));
      chk("cyc_hi", 64'(hi_out), 64'(m_hi));
      chk("cyc_lo", 64'(lo_out), 64'(m_lo));
    end
  end

  task automatic wait_idle(input string name);
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  // Issue one start pulse from idle and measure done/busy timing
  task automatic run_op(input logic sm, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, output int dcyc, output int bcyc,
                        output logic dz0, output logic dzd);
    @(posedge clk); #1;
    start_mult = sm;
    start_div  = sd;
    op_a       = a;
    op_b       = b;
    @(posedge clk); #1;  // E0 has just occurred
    start_mult = 1'b0;
    start_div  = 1'b0;
    dcyc = -1;
    bcyc = 0;
    dz0  = division_by_zero;
    dzd  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      bcyc++;
      if (done && dcyc < 0) begin
        dcyc = k;
        dzd  = division_by_zero;
      end
      @(posedge clk); #1;
    end
    chk("op_timeout", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc, bc;
    logic dz0, dzd;
    int   r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(division_by_zero), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);

    // Pin the reference model itself
    chk("ref_mul_7x-3", ref_mul(32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("ref_mul_min2", ref_mul(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
    chk("ref_div_-7/2", ref_div(32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref_div_7/-2", ref_div(32'd7, 32'hFFFF_FFFE), 64'h0000_0001_FFFF_FFFD);
    chk("ref_div_min/-1", ref_div(32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    reset = 1'b1;

    // 7 * -3 with timing
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, dc, bc, dz0, dzd);
    chk("mul7_done_cyc", 64'(dc), 64'd33);
    chk("mul7_busy_cyc", 64'(bc), 64'd34);
    chk("mul7_hi", 64'(hi_out), 64'hFFFF_FFFF);
    chk("mul7_lo", 64'(lo_out), 64'hFFFF_FFEB);

    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, dc, bc, dz0, dzd);
    chk("mulmin_hi", 64'(hi_out), 64'h4000_0000);
    chk("mulmin_lo", 64'(lo_out), 64'h0000_0000);

    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, dz0, dzd);
    chk("mulm1_hi", 64'(hi_out), 64'h0);
    chk("mulm1_lo", 64'(lo_out), 64'h1);

    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, dc, bc, dz0, dzd);
    chk("div-7_done_cyc", 64'(dc), 64'd33);
    chk("div-7_busy_cyc", 64'(bc), 64'd34);
    chk("div-7_lo", 64'(lo_out), 64'hFFFF_FFFD);
    chk("div-7_hi", 64'(hi_out), 64'hFFFF_FFFF);

    run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, dc, bc, dz0, dzd);
    chk("div7_lo", 64'(lo_out), 64'hFFFF_FFFD);
    chk("div7_hi", 64'(hi_out), 64'h1);

    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, dc, bc, dz0, dzd);
    chk("divmin_lo", 64'(lo_out), 64'h8000_0000);
    chk("divmin_hi", 64'(hi_out), 64'h0);
    chk("divmin_dz", 64'(division_by_zero), 64'd0);

    // Preset HI/LO to 0x12/0x34 (0x692 / 0x20), then divide by zero
    run_op(1'b0, 1'b1, 32'h0000_0692, 32'h0000_0020, dc, bc, dz0, dzd);
    chk("pre_hi", 64'(hi_out), 64'h12);
    chk("pre_lo", 64'(lo_out), 64'h34);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, dc, bc, dz0, dzd);
    chk("dz_done_cyc", 64'(dc), 64'd0);
    chk("dz_busy_cyc", 64'(bc), 64'd1);
    chk("dz_flag_at_done", 64'(dzd), 64'd1);
    chk("dz_flag_sticky", 64'(division_by_zero), 64'd1);
    chk("dz_hi_kept", 64'(hi_out), 64'h12);
    chk("dz_lo_kept", 64'(lo_out), 64'h34);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, dc, bc, dz0, dzd);
    chk("dz_cleared_at_start", 64'(dz0), 64'd0);
    chk("after_dz_lo", 64'(lo_out), 64'd12);

    // Both starts together: multiply wins
    run_op(1'b1, 1'b1, 32'd6, 32'hFFFF_FFF9, dc, bc, dz0, dzd);
    chk("both_hi", 64'(hi_out), 64'hFFFF_FFFF);
    chk("both_lo", 64'(lo_out), 64'hFFFF_FFD6);

    // Ignored start_div and operand changes while a multiply runs
    @(posedge clk); #1;
    start_mult = 1'b1;
    op_a = 32'h0001_0003;
    op_b = 32'h0002_0005;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start_div = 1'b1;
    op_a = 32'h0000_FFFF;
    op_b = 32'd3;
    @(posedge clk); #1;
    start_div = 1'b0;
    wait_idle("midop_timeout");
    chk("midop_hi", 64'(hi_out), 64'h0000_0002);
    chk("midop_lo", 64'(lo_out), 64'h000B_000F);
    chk("midop_dz", 64'(division_by_zero), 64'd0);

    // Reset in the middle of a divide
    @(posedge clk); #1;
    start_div = 1'b1;
    op_a = 32'd1000;
    op_b = 32'hFFFF_FFF9;
    @(posedge clk); #1;
    start_div = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_dz", 64'(division_by_zero), 64'd0);
    chk("arst_hi", 64'(hi_out), 64'd0);
    chk("arst_lo", 64'(lo_out), 64'd0);
    @(posedge clk); #1;
    chk("arst_done_held", 64'(done), 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, dc, bc, dz0, dzd);
    chk("post_rst_done_cyc", 64'(dc), 64'd33);
    chk("post_rst_hi", 64'(hi_out), 64'h0);
    chk("post_rst_lo", 64'(lo_out), 64'hFFFF_FFFE);

    // Random starts (including while busy) and operand churn
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      r = int'($urandom_range(0, 15));
      start_mult = (r == 0) || (r == 2);
      start_div  = (r == 1) || (r == 2) || (r == 3);
      op_a = pick_operand();
      op_b = pick_operand();
    end
    @(posedge clk); #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    wait_idle("rand_drain_timeout");
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
